// File: rtl/fpu_cvt_pkg.sv
// Shared constants and types for the FPU conversion-unit scheduler.
package fpu_cvt_pkg;

  localparam logic CVT_ITOF = 1'b0;
  localparam logic CVT_FTOI = 1'b1;

  localparam int MAX_NREQ = 8;
  localparam int ID_W     = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    HOLD     = 2'd2
  } req_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters that are valid and idle.
module rr_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] idle,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  logic [ID_W-1:0] rr_ptr;
  logic [NREQ-1:0] eligible;

  // Gating with rstn keeps req_ready low while reset is asserted.
  assign eligible = req_valid & idle & {NREQ{rstn}};

  // First pass scans from rr_ptr upward, second pass wraps below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && eligible[i] && (ID_W'(i) >= rr_ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && eligible[i]) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Schedules NREQ requesters onto one fixed-latency itof/ftoi unit and
// holds each result until its requester takes it.
//   state    | meaning
//   IDLE     | may accept a new request
//   INFLIGHT | op issued, tag travelling with the unit pipeline
//   HOLD     | result parked in resp_data, resp_valid high
module fpu_cvt_sched
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_op,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [32*NREQ-1:0]   resp_data,
  output logic                 cvt_valid,
  output logic                 cvt_op,
  output logic [31:0]          cvt_src,
  input  logic [31:0]          cvt_res,
  output logic                 busy
);

  req_state_t      state    [NREQ];
  req_state_t      state_nx [NREQ];
  logic [NREQ-1:0] idle;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            sel_op;
  logic [31:0]     sel_src;

  logic            tag_vld [LAT+1];
  logic [ID_W-1:0] tag_id  [LAT+1];
  logic            ret_vld;
  logic [ID_W-1:0] ret_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .idle      (idle),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign ret_vld   = tag_vld[LAT];
  assign ret_id    = tag_id[LAT];

  always_comb begin
    idle       = '0;
    resp_valid = '0;
    sel_op     = CVT_ITOF;
    sel_src    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idle[i]       = (state[i] == IDLE);
      resp_valid[i] = (state[i] == HOLD);
      if (grant[i]) begin
        sel_op  = req_op[i];
        sel_src = req_data[32*i +: 32];
      end
    end
    busy = ~&idle;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_nx[i] = state[i];
      case (state[i])
        IDLE:     if (grant[i]) state_nx[i] = INFLIGHT;
        INFLIGHT: if (ret_vld && (ret_id == ID_W'(i))) state_nx[i] = HOLD;
        HOLD:     if (resp_ready[i]) state_nx[i] = IDLE;
        default:  state_nx[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rstn) state[i] <= IDLE;
      else       state[i] <= state_nx[i];
    end
  end

  // Stage LAT lines up with cvt_res; cvt_res is only looked at under a valid tag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
      cvt_valid <= 1'b0;
      cvt_op    <= CVT_ITOF;
      cvt_src   <= '0;
      resp_data <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_idx;
      for (int k = 1; k <= LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      cvt_valid <= grant_any;
      if (grant_any) begin
        cvt_op  <= sel_op;
        cvt_src <= sel_src;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (ret_vld && (ret_id == ID_W'(i))) resp_data[32*i +: 32] <= cvt_res;
      end
    end
  end

endmodule
